// File: rtl/music_pkg.sv
// Shared types and constants for the music subsystem: sequencer state
// encoding, score end marker and note-timer width.
package music_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_LOAD   = 3'd2,
        ST_DECODE = 3'd3,
        ST_PLAY   = 3'd4,
        ST_DONE   = 3'd5
    } seq_state_t;

    localparam int              CNT_W          = 28;
    localparam logic [3:0]      BEAT_END       = 4'hF;
    localparam int              TONE_REST      = 0;
    localparam logic [CNT_W-1:0] GAP_CYCLES_DEF = 28'd2500000;

endpackage

// File: rtl/note_timer.sv
// Note-length down-counter: loaded with the decoded beat length, counts down
// while enabled and flags the last cycle and the audible (above-gap) region.
module note_timer
    import music_pkg::*;
#(
    parameter logic [CNT_W-1:0] GAP_CYCLES = GAP_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] load_val,
    output logic             expire,
    output logic             above_gap
);

    logic [CNT_W-1:0] cnt_r;

    // Counter register: clear beats load beats decrement; never underflows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (load) begin
            cnt_r <= load_val;
        end else if (en && (cnt_r != {CNT_W{1'b0}})) begin
            cnt_r <= cnt_r - CNT_W'(1'b1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expire    = (cnt_r == CNT_W'(1'b1));
    assign above_gap = (cnt_r > GAP_CYCLES);

endmodule

// File: rtl/note_sequencer.sv
// Score playback controller: walks the score ROM, hands each beat code to the
// beat decoder and gates the tone generator for the decoded note length.
module note_sequencer
    import music_pkg::*;
#(
    parameter int               ADDR_W     = 8,
    parameter int               TONE_W     = 6,
    parameter logic [CNT_W-1:0] GAP_CYCLES = GAP_CYCLES_DEF,
    parameter bit               LOOP       = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [TONE_W+3:0] rom_data,
    output logic [3:0]        beat,
    input  logic [CNT_W-1:0]  beat_cnt_parameter,
    output logic [TONE_W-1:0] tone_out,
    output logic              tone_valid,
    output logic              busy,
    output logic              song_done
);

    seq_state_t        state_r, state_s;
    logic [ADDR_W-1:0] addr_r, addr_s;
    logic [3:0]        beat_r, beat_s;
    logic [TONE_W-1:0] tone_r, tone_s;
    seq_state_t        adv_state_s;
    logic [ADDR_W-1:0] adv_addr_s;
    logic              t_load_s, t_en_s, t_clr_s;
    logic              t_expire_s, t_above_gap_s;
    logic [TONE_W-1:0] rom_tone_s;
    logic [3:0]        rom_beat_s;

    assign rom_tone_s = rom_data[TONE_W+3:4];
    assign rom_beat_s = rom_data[3:0];

    note_timer #(
        .GAP_CYCLES (GAP_CYCLES)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (t_clr_s),
        .load      (t_load_s),
        .en        (t_en_s),
        .load_val  (beat_cnt_parameter),
        .expire    (t_expire_s),
        .above_gap (t_above_gap_s)
    );

    // Address advance: the last ROM slot ends the song rather than wrapping.
    always_comb begin
        adv_state_s = ST_FETCH;
        adv_addr_s  = addr_r;
        if (addr_r == {ADDR_W{1'b1}}) begin
            adv_state_s = ST_DONE;
            adv_addr_s  = addr_r;
        end else begin
            adv_state_s = ST_FETCH;
            adv_addr_s  = addr_r + ADDR_W'(1'b1);
        end
    end

    // Next-state logic; stop overrides every state including a same-cycle start.
    always_comb begin
        state_s  = state_r;
        addr_s   = addr_r;
        beat_s   = beat_r;
        tone_s   = tone_r;
        t_load_s = 1'b0;
        t_en_s   = 1'b0;
        t_clr_s  = 1'b0;
        if (stop) begin
            state_s = ST_IDLE;
            addr_s  = {ADDR_W{1'b0}};
            t_clr_s = 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        addr_s  = {ADDR_W{1'b0}};
                        state_s = ST_FETCH;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_FETCH: begin
                    state_s = ST_LOAD;
                end
                ST_LOAD: begin
                    tone_s = rom_tone_s;
                    beat_s = rom_beat_s;
                    if ((rom_tone_s == TONE_W'(TONE_REST)) && (rom_beat_s == BEAT_END)) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    t_load_s = 1'b1;
                    // A zero length marks an undecodable beat: skip the entry.
                    if (beat_cnt_parameter == {CNT_W{1'b0}}) begin
                        state_s = adv_state_s;
                        addr_s  = adv_addr_s;
                    end else begin
                        state_s = ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (pause) begin
                        state_s = ST_PLAY;
                    end else begin
                        t_en_s = 1'b1;
                        if (t_expire_s) begin
                            state_s = adv_state_s;
                            addr_s  = adv_addr_s;
                        end else begin
                            state_s = ST_PLAY;
                        end
                    end
                end
                ST_DONE: begin
                    if (LOOP) begin
                        addr_s  = {ADDR_W{1'b0}};
                        state_s = ST_FETCH;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    addr_s  = {ADDR_W{1'b0}};
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            addr_r  <= {ADDR_W{1'b0}};
            beat_r  <= 4'h0;
            tone_r  <= {TONE_W{1'b0}};
        end else begin
            state_r <= state_s;
            addr_r  <= addr_s;
            beat_r  <= beat_s;
            tone_r  <= tone_s;
        end
    end

    assign rom_addr   = addr_r;
    assign beat       = beat_r;
    assign tone_out   = tone_r;
    assign tone_valid = (state_r == ST_PLAY) && t_above_gap_s && !pause;
    assign busy       = (state_r != ST_IDLE);
    assign song_done  = (state_r == ST_DONE);

endmodule

// File: tb/tb_note_sequencer.sv
// Self-checking bench for note_sequencer with a score ROM model, a stub beat
// decoder and a song-level reference model (note = n+3 cycles, n-GAP audible).
module tb_note_sequencer;

    localparam int GAP = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, stop, pause;
    logic [7:0]  rom_addr;
    logic [9:0]  rom_data;
    logic [3:0]  beat;
    logic [27:0] bcp;
    logic [5:0]  tone_out;
    logic        tone_valid, busy, song_done;

    logic        start_l, stop_l, pause_l;
    logic [7:0]  rom_addr_l;
    logic [9:0]  rom_data_l;
    logic [3:0]  beat_l;
    logic [27:0] bcp_l;
    logic [5:0]  tone_out_l;
    logic        tone_valid_l, busy_l, song_done_l;

    logic [9:0] rom   [256];
    logic [9:0] rom_l [256];

    int n_cmp = 0;
    int n_bad = 0;
    int exp_tone[$], exp_len[$], obs_tone[$], obs_len[$];
    int exp_busy;

    function automatic logic [27:0] decode(input logic [3:0] b);
        case (b)
            4'd0:    return 28'd20;
            4'd1:    return 28'd10;
            default: return 28'd0;
        endcase
    endfunction

    assign bcp   = decode(beat);
    assign bcp_l = decode(beat_l);

    always @(posedge clk) rom_data   <= rom[rom_addr];
    always @(posedge clk) rom_data_l <= rom_l[rom_addr_l];

    note_sequencer #(.GAP_CYCLES(28'd3), .LOOP(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .pause(pause),
        .rom_addr(rom_addr), .rom_data(rom_data), .beat(beat),
        .beat_cnt_parameter(bcp), .tone_out(tone_out), .tone_valid(tone_valid),
        .busy(busy), .song_done(song_done)
    );

    note_sequencer #(.GAP_CYCLES(28'd3), .LOOP(1'b1)) dut_loop (
        .clk(clk), .rst_n(rst_n), .start(start_l), .stop(stop_l), .pause(pause_l),
        .rom_addr(rom_addr_l), .rom_data(rom_data_l), .beat(beat_l),
        .beat_cnt_parameter(bcp_l), .tone_out(tone_out_l), .tone_valid(tone_valid_l),
        .busy(busy_l), .song_done(song_done_l)
    );

    function automatic logic [9:0] ent(input int t, input int b);
        logic [5:0] tt;
        logic [3:0] bb;
        tt = 6'(t);
        bb = 4'(b);
        return {tt, bb};
    endfunction

    task automatic fill_end();
        for (int a = 0; a < 256; a++) begin
            rom[a]   = ent(0, 15);
            rom_l[a] = ent(0, 15);
        end
    endtask

    task automatic load_scn1();
        fill_end();
        rom[0] = ent(5, 0);
        rom[1] = ent(7, 1);
        rom_l[0] = ent(5, 0);
        rom_l[1] = ent(7, 1);
    endtask

    // Song-level reference: each played note costs n+3 cycles with n-GAP audible.
    function automatic void model_song();
        int n;
        bit ended;
        logic [9:0] e;
        exp_tone.delete();
        exp_len.delete();
        exp_busy = 0;
        ended = 1'b0;
        for (int a = 0; a < 256 && !ended; a++) begin
            e = rom[a];
            n = int'(decode(e[3:0]));
            if (e[9:4] == 6'd0 && e[3:0] == 4'hF) begin
                exp_busy += 3;
                ended = 1'b1;
            end else begin
                exp_busy += 3 + n;
                if (n > GAP) begin
                    exp_tone.push_back(int'(e[9:4]));
                    exp_len.push_back(n - GAP);
                end
            end
        end
        if (!ended) exp_busy += 1;
    endfunction

    task automatic run_song(input string name, input int pf, input int pt, input int restart_at);
        int busy_n, done_n, cur_tone, cur_len, extra;
        obs_tone.delete();
        obs_len.delete();
        busy_n = 0; done_n = 0; cur_tone = 0; cur_len = 0; extra = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < exp_busy + 20; i++) begin
            pause = (i >= pf && i <= pt);
            start = (i == restart_at);
            #1;
            if (busy) busy_n++;
            if (song_done) done_n++;
            if (tone_valid) begin
                if (cur_len > 0 && int'(tone_out) != cur_tone) begin
                    obs_tone.push_back(cur_tone); obs_len.push_back(cur_len); cur_len = 0;
                end
                cur_tone = int'(tone_out);
                cur_len++;
            end else if (cur_len > 0) begin
                obs_tone.push_back(cur_tone); obs_len.push_back(cur_len); cur_len = 0;
            end
            if (song_done) break;
            @(negedge clk);
        end
        if (cur_len > 0) begin
            obs_tone.push_back(cur_tone); obs_len.push_back(cur_len);
        end
        pause = 1'b0;
        start = 1'b0;
        n_cmp++;
        if (done_n !== 1) begin
            n_bad++; $display("FAIL %s song_done_count got %0d want 1", name, done_n);
        end
        n_cmp++;
        if (busy_n !== exp_busy) begin
            n_bad++; $display("FAIL %s busy_cycles got %0d want %0d", name, busy_n, exp_busy);
        end
        n_cmp++;
        if (obs_len.size() !== exp_len.size()) begin
            n_bad++; $display("FAIL %s run_count got %0d want %0d", name, obs_len.size(), exp_len.size());
        end else begin
            for (int k = 0; k < exp_len.size(); k++) begin
                n_cmp++;
                if (obs_tone[k] !== exp_tone[k] || obs_len[k] !== exp_len[k]) begin
                    n_bad++;
                    $display("FAIL %s run%0d got tone %0d x%0d want tone %0d x%0d",
                             name, k, obs_tone[k], obs_len[k], exp_tone[k], exp_len[k]);
                end
            end
        end
        @(negedge clk); #1;
        n_cmp++;
        if (busy !== 1'b0 || tone_valid !== 1'b0) begin
            n_bad++; $display("FAIL %s idle_after got busy=%b valid=%b want 0/0", name, busy, tone_valid);
        end
        for (int i = 0; i < 5; i++) begin
            if (song_done) extra++;
            @(negedge clk); #1;
        end
        n_cmp++;
        if (extra !== 0) begin
            n_bad++; $display("FAIL %s extra_song_done got %0d want 0", name, extra);
        end
    endtask

    task automatic check_zero(input string name);
        n_cmp++;
        if (rom_addr !== 8'd0 || beat !== 4'd0 || tone_out !== 6'd0 ||
            tone_valid !== 1'b0 || busy !== 1'b0 || song_done !== 1'b0) begin
            n_bad++;
            $display("FAIL %s got addr=%0d beat=%0d tone=%0d valid=%b busy=%b done=%b want all 0",
                     name, rom_addr, beat, tone_out, tone_valid, busy, song_done);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0;
        start_l = 1'b0; stop_l = 1'b0; pause_l = 1'b0;
        fill_end();
        repeat (3) @(negedge clk);
        #1 check_zero("reset_held");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1 check_zero("reset_released");
    endtask

    task automatic test_basic();
        load_scn1();
        exp_tone = '{5, 7};
        exp_len  = '{17, 7};
        exp_busy = 39;
        run_song("basic", -1, -1, -1);
    endtask

    task automatic test_skip();
        fill_end();
        rom[0] = ent(5, 2);
        rom[1] = ent(9, 1);
        exp_tone = '{9};
        exp_len  = '{7};
        exp_busy = 19;
        run_song("skip", -1, -1, -1);
    endtask

    task automatic test_pause();
        load_scn1();
        exp_tone = '{5, 5, 7};
        exp_len  = '{5, 12, 7};
        exp_busy = 45;
        run_song("pause", 8, 13, -1);
    endtask

    task automatic test_stop();
        int bad_after;
        load_scn1();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (30) @(negedge clk);
        stop = 1'b1;
        #1;
        n_cmp++;
        if (tone_valid !== 1'b1 || tone_out !== 6'd7) begin
            n_bad++; $display("FAIL stop_pre got valid=%b tone=%0d want 1/7", tone_valid, tone_out);
        end
        @(negedge clk); stop = 1'b0; #1;
        n_cmp++;
        if (busy !== 1'b0 || tone_valid !== 1'b0 || rom_addr !== 8'd0) begin
            n_bad++;
            $display("FAIL stop_post got busy=%b valid=%b addr=%0d want 0/0/0", busy, tone_valid, rom_addr);
        end
        bad_after = 0;
        for (int i = 0; i < 40; i++) begin
            if (song_done || busy) bad_after++;
            @(negedge clk); #1;
        end
        n_cmp++;
        if (bad_after !== 0) begin
            n_bad++; $display("FAIL stop_quiet got %0d active cycles want 0", bad_after);
        end
        exp_tone = '{5, 7};
        exp_len  = '{17, 7};
        exp_busy = 39;
        run_song("stop_replay", -1, -1, -1);
    endtask

    task automatic test_loop();
        int dones[$];
        int low_busy;
        fill_end();
        load_scn1();
        low_busy = 0;
        @(negedge clk); start_l = 1'b1;
        @(negedge clk); start_l = 1'b0;
        for (int i = 0; i < 3 * 39 + 5; i++) begin
            #1;
            if (song_done_l) dones.push_back(i);
            if (!busy_l) low_busy++;
            @(negedge clk);
        end
        n_cmp++;
        if (dones.size() !== 3) begin
            n_bad++; $display("FAIL loop_done_count got %0d want 3", dones.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (dones[k] !== 38 + 39 * k) begin
                    n_bad++; $display("FAIL loop_done%0d got cycle %0d want %0d", k, dones[k], 38 + 39 * k);
                end
            end
        end
        n_cmp++;
        if (low_busy !== 0) begin
            n_bad++; $display("FAIL loop_busy got %0d low cycles want 0", low_busy);
        end
        stop_l = 1'b1;
        @(negedge clk); stop_l = 1'b0; #1;
        n_cmp++;
        if (busy_l !== 1'b0 || rom_addr_l !== 8'd0) begin
            n_bad++; $display("FAIL loop_stop got busy=%b addr=%0d want 0/0", busy_l, rom_addr_l);
        end
    endtask

    task automatic test_reset_mid();
        load_scn1();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        n_cmp++;
        if (tone_valid !== 1'b1 || tone_out !== 6'd5) begin
            n_bad++; $display("FAIL rst_mid_pre got valid=%b tone=%0d want 1/5", tone_valid, tone_out);
        end
        #1 rst_n = 1'b0;
        #1 check_zero("rst_mid_async");
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); #1 check_zero("rst_mid_after");
    endtask

    task automatic test_start_ignored();
        load_scn1();
        exp_tone = '{5, 7};
        exp_len  = '{17, 7};
        exp_busy = 39;
        run_song("start_busy", -1, -1, 10);
    endtask

    task automatic test_last_addr();
        for (int a = 0; a < 256; a++) rom[a] = ent(1, 1);
        model_song();
        run_song("last_addr", -1, -1, -1);
    endtask

    task automatic test_random();
        int len, r, b, t;
        for (int s = 0; s < 6; s++) begin
            fill_end();
            len = $urandom_range(1, 8);
            for (int a = 0; a < len; a++) begin
                r = $urandom_range(0, 3);
                b = (r < 3) ? r : $urandom_range(3, 14);
                t = $urandom_range(0, 63);
                rom[a] = ent(t, b);
            end
            model_song();
            run_song($sformatf("random%0d", s), -1, -1, -1);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_skip();
        test_pause();
        test_stop();
        test_loop();
        test_reset_mid();
        test_start_ignored();
        test_last_addr();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
